// File: rtl/alu_reservation_station_if.sv
// Dispatch / CDB snoop / ALU issue / release bundle for the ALU reservation station.
// ALU_RS_LSCDB_EN adds the load/store CDB snoop port.
interface alu_rs_if #(
  parameter int IDX_W  = 2,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int OP_W   = 5
);
  logic              flush;
  logic              disp_valid;
  logic [OP_W-1:0]   disp_op;
  logic [TAG_W-1:0]  disp_src1_tag;
  logic [DATA_W-1:0] disp_src1_data;
  logic [TAG_W-1:0]  disp_src2_tag;
  logic [DATA_W-1:0] disp_src2_data;
  logic [TAG_W-1:0]  disp_dest_tag;
  logic [ADDR_W-1:0] disp_pc;
  logic              rs_full;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
`ifdef ALU_RS_LSCDB_EN
  logic              ls_cdb_valid;
  logic [TAG_W-1:0]  ls_cdb_tag;
  logic [DATA_W-1:0] ls_cdb_data;
`endif
  logic              alu_ready;
  logic              alu_issue_valid;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [TAG_W-1:0]  alu_dest_tag;
  logic [ADDR_W-1:0] alu_pc;
  logic [IDX_W-1:0]  alu_rs_num;
  logic              alu_finish;
  logic [IDX_W-1:0]  alu_free_num;

  modport master (
`ifdef ALU_RS_LSCDB_EN
    output ls_cdb_valid, ls_cdb_tag, ls_cdb_data,
`endif
    output flush, disp_valid, disp_op, disp_src1_tag, disp_src1_data,
    output disp_src2_tag, disp_src2_data, disp_dest_tag, disp_pc,
    output cdb_valid, cdb_tag, cdb_data, alu_ready, alu_finish, alu_free_num,
    input  rs_full, alu_issue_valid, alu_op, alu_a, alu_b, alu_dest_tag, alu_pc, alu_rs_num
  );

  modport slave (
`ifdef ALU_RS_LSCDB_EN
    input  ls_cdb_valid, ls_cdb_tag, ls_cdb_data,
`endif
    input  flush, disp_valid, disp_op, disp_src1_tag, disp_src1_data,
    input  disp_src2_tag, disp_src2_data, disp_dest_tag, disp_pc,
    input  cdb_valid, cdb_tag, cdb_data, alu_ready, alu_finish, alu_free_num,
    output rs_full, alu_issue_valid, alu_op, alu_a, alu_b, alu_dest_tag, alu_pc, alu_rs_num
  );
endinterface

// File: rtl/alu_reservation_station.sv
// ALU reservation station: per-entry CDB snooping, lowest-index dispatch/issue, release on aluFinish.
// Optional ALU_RS_LSCDB_EN: second (load/store) CDB snooped alongside the ALU-CDB.
module alu_rs_entry #(
  parameter int               TAG_W    = 4,
  parameter logic [TAG_W-1:0] TAG_FREE = {TAG_W{1'b1}},
  parameter int               DATA_W   = 32,
  parameter int               ADDR_W   = 32,
  parameter int               OP_W     = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_alloc,
  input  logic              i_issue,
  input  logic              i_release,
  input  logic [OP_W-1:0]   i_op,
  input  logic [TAG_W-1:0]  i_src1_tag,
  input  logic [DATA_W-1:0] i_src1_data,
  input  logic [TAG_W-1:0]  i_src2_tag,
  input  logic [DATA_W-1:0] i_src2_data,
  input  logic [TAG_W-1:0]  i_dest_tag,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic              i_cdb_valid,
  input  logic [TAG_W-1:0]  i_cdb_tag,
  input  logic [DATA_W-1:0] i_cdb_data,
  input  logic              i_ls_valid,
  input  logic [TAG_W-1:0]  i_ls_tag,
  input  logic [DATA_W-1:0] i_ls_data,
  output logic              o_free,
  output logic              o_ready,
  output logic [OP_W-1:0]   o_op,
  output logic [DATA_W-1:0] o_a,
  output logic [DATA_W-1:0] o_b,
  output logic [TAG_W-1:0]  o_dest_tag,
  output logic [ADDR_W-1:0] o_pc
);
  typedef enum logic [1:0] {S_FREE, S_WAIT, S_READY, S_ISSUED} state_t;

  state_t            r_state;
  logic [TAG_W-1:0]  r_t1, r_t2, r_dest;
  logic [DATA_W-1:0] r_d1, r_d2;
  logic [OP_W-1:0]   r_op;
  logic [ADDR_W-1:0] r_pc;
  logic [TAG_W-1:0]  w_t1_in, w_t2_in, w_t1_nx, w_t2_nx;
  logic [DATA_W-1:0] w_d1_in, w_d2_in, w_d1_nx, w_d2_nx;

  // ALU-CDB is tested first so it wins when both buses carry the same tag.
  function automatic logic [TAG_W+DATA_W-1:0] f_resolve(
    input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] data,
    input logic cv, input logic [TAG_W-1:0] ct, input logic [DATA_W-1:0] cd,
    input logic lv, input logic [TAG_W-1:0] lt, input logic [DATA_W-1:0] ld);
    if (tag != TAG_FREE && cv && ct == tag)      return {TAG_FREE, cd};
    else if (tag != TAG_FREE && lv && lt == tag) return {TAG_FREE, ld};
    else                                         return {tag, data};
  endfunction

  // A free entry resolves the incoming dispatch operands (same-cycle bypass);
  // an occupied one resolves its stored operands.
  always_comb begin
    w_t1_in = (r_state == S_FREE) ? i_src1_tag  : r_t1;
    w_d1_in = (r_state == S_FREE) ? i_src1_data : r_d1;
    w_t2_in = (r_state == S_FREE) ? i_src2_tag  : r_t2;
    w_d2_in = (r_state == S_FREE) ? i_src2_data : r_d2;
    {w_t1_nx, w_d1_nx} = f_resolve(w_t1_in, w_d1_in, i_cdb_valid, i_cdb_tag, i_cdb_data,
                                   i_ls_valid, i_ls_tag, i_ls_data);
    {w_t2_nx, w_d2_nx} = f_resolve(w_t2_in, w_d2_in, i_cdb_valid, i_cdb_tag, i_cdb_data,
                                   i_ls_valid, i_ls_tag, i_ls_data);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_FREE;
      r_t1    <= TAG_FREE;
      r_t2    <= TAG_FREE;
      r_d1    <= '0;
      r_d2    <= '0;
      r_op    <= '0;
      r_dest  <= TAG_FREE;
      r_pc    <= '0;
    end else if (i_flush) begin
      r_state <= S_FREE;
    end else begin
      case (r_state)
        S_FREE: if (i_alloc) begin
          r_op    <= i_op;
          r_dest  <= i_dest_tag;
          r_pc    <= i_pc;
          r_t1    <= w_t1_nx;
          r_d1    <= w_d1_nx;
          r_t2    <= w_t2_nx;
          r_d2    <= w_d2_nx;
          r_state <= (w_t1_nx == TAG_FREE && w_t2_nx == TAG_FREE) ? S_READY : S_WAIT;
        end
        S_WAIT: begin
          r_t1 <= w_t1_nx;
          r_d1 <= w_d1_nx;
          r_t2 <= w_t2_nx;
          r_d2 <= w_d2_nx;
          if (w_t1_nx == TAG_FREE && w_t2_nx == TAG_FREE) r_state <= S_READY;
        end
        S_READY:  if (i_issue)   r_state <= S_ISSUED;
        S_ISSUED: if (i_release) r_state <= S_FREE;
        default:                 r_state <= S_FREE;
      endcase
    end
  end

  assign o_free     = (r_state == S_FREE);
  assign o_ready    = (r_state == S_READY);
  assign o_op       = r_op;
  assign o_a        = r_d1;
  assign o_b        = r_d2;
  assign o_dest_tag = r_dest;
  assign o_pc       = r_pc;
endmodule

module alu_reservation_station #(
  parameter int               ENTRIES  = 4,
  parameter int               IDX_W    = 2,
  parameter int               TAG_W    = 4,
  parameter logic [TAG_W-1:0] TAG_FREE = {TAG_W{1'b1}},
  parameter int               DATA_W   = 32,
  parameter int               ADDR_W   = 32,
  parameter int               OP_W     = 5
) (
  input logic   clk,
  input logic   rst,
  alu_rs_if.slave bus
);
  logic [ENTRIES-1:0]             w_free, w_ready;
  logic [ENTRIES-1:0][OP_W-1:0]   w_op;
  logic [ENTRIES-1:0][DATA_W-1:0] w_a, w_b;
  logic [ENTRIES-1:0][TAG_W-1:0]  w_dest;
  logic [ENTRIES-1:0][ADDR_W-1:0] w_pc;
  logic [IDX_W-1:0]               w_alloc_idx, w_issue_idx;
  logic                           w_dispatch, w_fire;
  logic                           w_ls_valid;
  logic [TAG_W-1:0]               w_ls_tag;
  logic [DATA_W-1:0]              w_ls_data;

  logic              r_issue_valid;
  logic [OP_W-1:0]   r_op;
  logic [DATA_W-1:0] r_a, r_b;
  logic [TAG_W-1:0]  r_dest;
  logic [ADDR_W-1:0] r_pc;
  logic [IDX_W-1:0]  r_rs_num;

`ifdef ALU_RS_LSCDB_EN
  assign w_ls_valid = bus.ls_cdb_valid;
  assign w_ls_tag   = bus.ls_cdb_tag;
  assign w_ls_data  = bus.ls_cdb_data;
`else
  assign w_ls_valid = 1'b0;
  assign w_ls_tag   = TAG_FREE;
  assign w_ls_data  = '0;
`endif

  // Descending scan leaves the lowest matching index.
  always_comb begin
    w_alloc_idx = '0;
    w_issue_idx = '0;
    for (int i = ENTRIES-1; i >= 0; i--) begin
      if (w_free[i])  w_alloc_idx = IDX_W'(i);
      if (w_ready[i]) w_issue_idx = IDX_W'(i);
    end
  end

  assign bus.rs_full = ~|w_free;
  assign w_dispatch  = bus.disp_valid && !bus.rs_full && !bus.flush;
  assign w_fire      = bus.alu_ready && (|w_ready) && !bus.flush;

  for (genvar g = 0; g < ENTRIES; g++) begin : g_ent
    alu_rs_entry #(
      .TAG_W(TAG_W), .TAG_FREE(TAG_FREE), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .OP_W(OP_W)
    ) u_ent (
      .clk         (clk),
      .rst         (rst),
      .i_flush     (bus.flush),
      .i_alloc     (w_dispatch && (w_alloc_idx == IDX_W'(g))),
      .i_issue     (w_fire && (w_issue_idx == IDX_W'(g))),
      .i_release   (bus.alu_finish && (bus.alu_free_num == IDX_W'(g))),
      .i_op        (bus.disp_op),
      .i_src1_tag  (bus.disp_src1_tag),
      .i_src1_data (bus.disp_src1_data),
      .i_src2_tag  (bus.disp_src2_tag),
      .i_src2_data (bus.disp_src2_data),
      .i_dest_tag  (bus.disp_dest_tag),
      .i_pc        (bus.disp_pc),
      .i_cdb_valid (bus.cdb_valid),
      .i_cdb_tag   (bus.cdb_tag),
      .i_cdb_data  (bus.cdb_data),
      .i_ls_valid  (w_ls_valid),
      .i_ls_tag    (w_ls_tag),
      .i_ls_data   (w_ls_data),
      .o_free      (w_free[g]),
      .o_ready     (w_ready[g]),
      .o_op        (w_op[g]),
      .o_a         (w_a[g]),
      .o_b         (w_b[g]),
      .o_dest_tag  (w_dest[g]),
      .o_pc        (w_pc[g])
    );
  end

  // Issue payload holds between strobes; only the valid bit pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_issue_valid <= 1'b0;
      r_op          <= '0;
      r_a           <= '0;
      r_b           <= '0;
      r_dest        <= TAG_FREE;
      r_pc          <= '0;
      r_rs_num      <= '0;
    end else begin
      r_issue_valid <= w_fire;
      if (w_fire) begin
        r_op     <= w_op[w_issue_idx];
        r_a      <= w_a[w_issue_idx];
        r_b      <= w_b[w_issue_idx];
        r_dest   <= w_dest[w_issue_idx];
        r_pc     <= w_pc[w_issue_idx];
        r_rs_num <= w_issue_idx;
      end
    end
  end

  assign bus.alu_issue_valid = r_issue_valid;
  assign bus.alu_op          = r_op;
  assign bus.alu_a           = r_a;
  assign bus.alu_b           = r_b;
  assign bus.alu_dest_tag    = r_dest;
  assign bus.alu_pc          = r_pc;
  assign bus.alu_rs_num      = r_rs_num;
endmodule

// File: tb/tb_alu_reservation_station.sv
// Randomized scoreboard bench: reference model predicts each issue, monitor compares on the strobe.
module tb_alu_reservation_station;
  localparam logic [3:0] TF = 4'hF;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  bit   mon_en = 1'b0;

  alu_rs_if bus ();
  alu_reservation_station dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [4:0]  op;
    logic [31:0] a, b;
    logic [3:0]  dest;
    logic [31:0] pc;
    logic [1:0]  num;
  } exp_t;
  exp_t q[$];

  // Reference model: an entry is occupied, maybe issued, with two operands that
  // are either a known value or a pending producer tag.
  bit          m_occ[4], m_iss[4];
  logic [3:0]  m_t1[4], m_t2[4], m_dest[4];
  logic [31:0] m_v1[4], m_v2[4], m_pc[4];
  logic [4:0]  m_op[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit m_full();
    for (int i = 0; i < 4; i++) if (!m_occ[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit snoop_hit(input logic [3:0] t);
    return t != TF && bus.cdb_valid && bus.cdb_tag == t;
  endfunction

  // Predict the effect of the inputs now on the bus at the coming edge.
  task automatic model_step();
    int   fi = -1, ri = -1;
    logic [1:0] fn = bus.alu_free_num;
    bit   rel;
    exp_t e;
    for (int i = 3; i >= 0; i--) begin
      if (!m_occ[i]) fi = i;
      if (m_occ[i] && !m_iss[i] && m_t1[i] == TF && m_t2[i] == TF) ri = i;
    end
    rel = bus.alu_finish && m_occ[fn] && m_iss[fn];
    if (bus.flush) begin
      for (int i = 0; i < 4; i++) begin m_occ[i] = 0; m_iss[i] = 0; end
      return;
    end
    if (bus.alu_ready && ri >= 0) begin
      e.cyc = cyc + 1; e.op = m_op[ri]; e.a = m_v1[ri]; e.b = m_v2[ri];
      e.dest = m_dest[ri]; e.pc = m_pc[ri]; e.num = 2'(ri);
      q.push_back(e);
      m_iss[ri] = 1;
    end
    if (rel) begin m_occ[fn] = 0; m_iss[fn] = 0; end
    for (int i = 0; i < 4; i++) if (m_occ[i] && !m_iss[i]) begin
      if (snoop_hit(m_t1[i])) begin m_t1[i] = TF; m_v1[i] = bus.cdb_data; end
      if (snoop_hit(m_t2[i])) begin m_t2[i] = TF; m_v2[i] = bus.cdb_data; end
    end
    if (bus.disp_valid && fi >= 0) begin
      m_occ[fi] = 1; m_iss[fi] = 0;
      m_op[fi] = bus.disp_op; m_dest[fi] = bus.disp_dest_tag; m_pc[fi] = bus.disp_pc;
      m_t1[fi] = bus.disp_src1_tag; m_v1[fi] = bus.disp_src1_data;
      m_t2[fi] = bus.disp_src2_tag; m_v2[fi] = bus.disp_src2_data;
      if (snoop_hit(m_t1[fi])) begin m_t1[fi] = TF; m_v1[fi] = bus.cdb_data; end
      if (snoop_hit(m_t2[fi])) begin m_t2[fi] = TF; m_v2[fi] = bus.cdb_data; end
    end
  endtask

  // Monitor: every cycle the strobe must match whether the model expected an issue now.
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      bit exp_v;
      exp_v = q.size() > 0 && q[0].cyc == cyc;
      chk("issue_valid", 64'(bus.alu_issue_valid), 64'(exp_v));
      if (exp_v) begin
        exp_t e;
        e = q.pop_front();
        if (bus.alu_issue_valid) begin
          chk("alu_op", 64'(bus.alu_op), 64'(e.op));
          chk("alu_a", 64'(bus.alu_a), 64'(e.a));
          chk("alu_b", 64'(bus.alu_b), 64'(e.b));
          chk("alu_dest_tag", 64'(bus.alu_dest_tag), 64'(e.dest));
          chk("alu_pc", 64'(bus.alu_pc), 64'(e.pc));
          chk("alu_rs_num", 64'(bus.alu_rs_num), 64'(e.num));
        end
      end
    end
  end

  task automatic idle_inputs();
    bus.flush = 0; bus.disp_valid = 0; bus.disp_op = '0;
    bus.disp_src1_tag = TF; bus.disp_src1_data = '0;
    bus.disp_src2_tag = TF; bus.disp_src2_data = '0;
    bus.disp_dest_tag = '0; bus.disp_pc = '0;
    bus.cdb_valid = 0; bus.cdb_tag = '0; bus.cdb_data = '0;
    bus.alu_ready = 0; bus.alu_finish = 0; bus.alu_free_num = '0;
`ifdef ALU_RS_LSCDB_EN
    bus.ls_cdb_valid = 0; bus.ls_cdb_tag = '0; bus.ls_cdb_data = '0;
`endif
  endtask

  task automatic rand_inputs(input int n);
    int il[$];
    bus.flush         = ($urandom % 50) == 0;
    bus.disp_valid    = ($urandom % 4) != 0;
    bus.disp_op       = 5'($urandom);
    bus.disp_src1_tag = ($urandom % 3 == 0) ? 4'($urandom % 15) : TF;
    bus.disp_src2_tag = ($urandom % 3 == 0) ? 4'($urandom % 15) : TF;
    bus.disp_src1_data = $urandom;
    bus.disp_src2_data = $urandom;
    bus.disp_dest_tag = 4'($urandom);
    bus.disp_pc       = $urandom;
    bus.cdb_valid     = $urandom % 2;
    bus.cdb_tag       = 4'($urandom);
    bus.cdb_data      = $urandom;
    bus.alu_ready     = (n % 100 < 20) ? 1'b0 : (($urandom % 4) != 0);
    for (int i = 0; i < 4; i++) if (m_iss[i]) il.push_back(i);
    bus.alu_free_num  = 2'($urandom);
    bus.alu_finish    = 0;
    if (il.size() > 0 && $urandom % 2 == 1) begin
      bus.alu_finish   = 1;
      bus.alu_free_num = 2'(il[$urandom % il.size()]);
    end else if ($urandom % 8 == 0) begin
      bus.alu_finish = 1;
    end
  endtask

  initial begin
    idle_inputs();
    for (int i = 0; i < 4; i++) begin m_occ[i] = 0; m_iss[i] = 0; end
    repeat (2) @(negedge clk);
    chk("reset_rs_full", 64'(bus.rs_full), 64'd0);
    chk("reset_issue_valid", 64'(bus.alu_issue_valid), 64'd0);
    chk("reset_dest_tag", 64'(bus.alu_dest_tag), 64'(TF));
    chk("reset_a", 64'(bus.alu_a), 64'd0);
    chk("reset_rs_num", 64'(bus.alu_rs_num), 64'd0);
    rst = 1;
    mon_en = 1;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      chk("rs_full", 64'(bus.rs_full), 64'(m_full()));
      rand_inputs(n);
      model_step();
    end
    @(negedge clk);
    idle_inputs();
    model_step();
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    mon_en = 0;

    // Async reset while an issue strobe is being presented.
    bus.flush = 1;
    @(negedge clk);
    bus.flush = 0; bus.disp_valid = 1; bus.alu_ready = 1;
    bus.disp_src1_data = 32'd5; bus.disp_src2_data = 32'd7; bus.disp_dest_tag = 4'd3;
    @(negedge clk);
    bus.disp_valid = 0;
    @(posedge clk);
    #1;
    chk("pre_reset_issue_valid", 64'(bus.alu_issue_valid), 64'd1);
    chk("pre_reset_a", 64'(bus.alu_a), 64'd5);
    chk("pre_reset_rs_num", 64'(bus.alu_rs_num), 64'd0);
    #2 rst = 0;
    #1;
    chk("async_reset_issue_valid", 64'(bus.alu_issue_valid), 64'd0);
    chk("async_reset_dest_tag", 64'(bus.alu_dest_tag), 64'(TF));
    chk("async_reset_a", 64'(bus.alu_a), 64'd0);
    chk("async_reset_rs_full", 64'(bus.rs_full), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
